// File: rtl/csync_vsep_pkg.sv
// rtl/csync_vsep_pkg.sv - encodings and helpers shared by the sync separator and the PAL/NTSC detector
package csync_vsep_pkg;

  localparam logic FALSE = 1'b0;
  localparam logic TRUE  = 1'b1;

  localparam int CNT_W = 16;
  localparam int RUN_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LINE = 2'b01,
    ST_VERT = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    PC_GLITCH = 2'b00,
    PC_NORMAL = 2'b01,
    PC_BROAD  = 2'b10
  } pulse_class_e;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
    return (v == {RUN_W{1'b1}}) ? v : v + RUN_W'(1);
  endfunction

endpackage

// File: rtl/csync_pulse_meas.sv
// rtl/csync_pulse_meas.sv - csync synchroniser, low/high width counters, pulse classification and timeout
module csync_pulse_meas
  import csync_vsep_pkg::*;
#(
  parameter int GLITCH_CLKS  = 10,
  parameter int BROAD_CLKS   = 100,
  parameter int TIMEOUT_CLKS = 1000
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         csync_in,
  output logic         csync_s,
  output logic         pulse_valid,
  output pulse_class_e pulse_class,
  output logic         timeout
);

  localparam logic [CNT_W-1:0] GLITCH_W  = CNT_W'(GLITCH_CLKS);
  localparam logic [CNT_W-1:0] BROAD_W   = CNT_W'(BROAD_CLKS);
  localparam logic [CNT_W-1:0] TIMEOUT_W = CNT_W'(TIMEOUT_CLKS);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic             pulse_valid_q, pulse_valid_d;
  pulse_class_e     pulse_class_q, pulse_class_d;
  logic             rise, fall;

  always_comb begin
    sync1_d = csync_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise    = sync2_q & ~prev_q;
    fall    = ~sync2_q & prev_q;

    // lo_cnt holds its value while high so the rising-edge cycle still sees the full width
    lo_cnt_d = lo_cnt_q;
    if (!sync2_q) begin
      lo_cnt_d = fall ? CNT_W'(1) : sat_inc_cnt(lo_cnt_q);
    end
    hi_cnt_d = sync2_q ? sat_inc_cnt(hi_cnt_q) : '0;

    pulse_valid_d = rise;
    if (lo_cnt_q < GLITCH_W) begin
      pulse_class_d = PC_GLITCH;
    end else if (lo_cnt_q >= BROAD_W) begin
      pulse_class_d = PC_BROAD;
    end else begin
      pulse_class_d = PC_NORMAL;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      prev_q        <= 1'b1;
      lo_cnt_q      <= '0;
      hi_cnt_q      <= '0;
      pulse_valid_q <= 1'b0;
      pulse_class_q <= PC_GLITCH;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      lo_cnt_q      <= lo_cnt_d;
      hi_cnt_q      <= hi_cnt_d;
      pulse_valid_q <= pulse_valid_d;
      pulse_class_q <= pulse_class_d;
    end
  end

  assign csync_s     = sync2_q;
  assign pulse_valid = pulse_valid_q;
  assign pulse_class = pulse_class_q;
  assign timeout     = (hi_cnt_q == TIMEOUT_W);

endmodule

// File: rtl/csync_vsep.sv
// rtl/csync_vsep.sv - composite sync separator: run counters, lock/vertical FSM and field counter
module csync_vsep
  import csync_vsep_pkg::*;
#(
  parameter int CLK_FREQ    = 10_000_000,
  parameter int GLITCH_NS   = 1000,
  parameter int BROAD_US    = 10,
  parameter int BROAD_MIN   = 3,
  parameter int LOCK_PULSES = 4,
  parameter int TIMEOUT_US  = 100
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       csync_in,
  output logic       csync_out,
  output logic       vsync_out,
  output logic       locked,
  output logic [7:0] field_count
);

  localparam int GLITCH_CLKS  = CLK_FREQ / 1_000_000 * GLITCH_NS / 1000;
  localparam int BROAD_CLKS   = CLK_FREQ / 1_000_000 * BROAD_US;
  localparam int TIMEOUT_CLKS = CLK_FREQ / 1_000_000 * TIMEOUT_US;

  localparam logic [RUN_W-1:0] BROAD_MIN_W = RUN_W'(BROAD_MIN);
  localparam logic [RUN_W-1:0] LOCK_W      = RUN_W'(LOCK_PULSES);

  logic             csync_s, pulse_valid, timeout;
  pulse_class_e     pulse_class;
  state_e           state_q, state_d;
  logic [RUN_W-1:0] broad_run_q, broad_run_d;
  logic [RUN_W-1:0] norm_run_q, norm_run_d;
  logic [7:0]       field_q, field_d;
  logic             vsync_q, vsync_d;
  logic             locked_q, locked_d;

  csync_pulse_meas #(
    .GLITCH_CLKS (GLITCH_CLKS),
    .BROAD_CLKS  (BROAD_CLKS),
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_meas (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .csync_in   (csync_in),
    .csync_s    (csync_s),
    .pulse_valid(pulse_valid),
    .pulse_class(pulse_class),
    .timeout    (timeout)
  );

  always_comb begin
    state_d     = state_q;
    broad_run_d = broad_run_q;
    norm_run_d  = norm_run_q;
    field_d     = field_q;

    if (timeout) begin
      state_d     = ST_IDLE;
      broad_run_d = '0;
      norm_run_d  = '0;
    end else if (pulse_valid && pulse_class != PC_GLITCH) begin
      if (pulse_class == PC_BROAD) begin
        broad_run_d = sat_inc_run(broad_run_q);
        norm_run_d  = '0;
      end else begin
        norm_run_d  = sat_inc_run(norm_run_q);
        broad_run_d = '0;
      end
      // transitions look at the updated run counts so they land in the same cycle
      case (state_q)
        ST_IDLE: if (pulse_class == PC_NORMAL && norm_run_d >= LOCK_W) state_d = ST_LINE;
        ST_LINE: if (pulse_class == PC_BROAD && broad_run_d >= BROAD_MIN_W) begin
          state_d = ST_VERT;
          field_d = field_q + 8'd1;
        end
        ST_VERT: if (pulse_class == PC_NORMAL) state_d = ST_LINE;
        default: state_d = ST_IDLE;
      endcase
    end

    locked_d = (state_d != ST_IDLE);
    vsync_d  = (state_d == ST_VERT) ? FALSE : TRUE;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      broad_run_q <= '0;
      norm_run_q  <= '0;
      field_q     <= '0;
      vsync_q     <= 1'b1;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      broad_run_q <= broad_run_d;
      norm_run_q  <= norm_run_d;
      field_q     <= field_d;
      vsync_q     <= vsync_d;
      locked_q    <= locked_d;
    end
  end

  assign csync_out   = csync_s;
  assign vsync_out   = vsync_q;
  assign locked      = locked_q;
  assign field_count = field_q;

endmodule

// File: tb/tb_csync_vsep.sv
// tb/tb_csync_vsep.sv - self-checking bench for csync_vsep against a pulse-level model
module tb_csync_vsep;

  localparam int TMO  = 1000;
  localparam int GLI  = 10;
  localparam int BRD  = 100;
  localparam int BMIN = 3;
  localparam int LOCKN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, csync_in, csync_out, vsync_out, locked;
  logic [7:0] field_count;
  logic       rst2, csync_in2, csync_out2, vsync_out2, locked2;
  logic [7:0] field_count2;

  csync_vsep dut (
    .clk_in(clk), .rst_in(rst), .csync_in(csync_in), .csync_out(csync_out),
    .vsync_out(vsync_out), .locked(locked), .field_count(field_count)
  );

  csync_vsep #(.CLK_FREQ(1_000_000)) dut2 (
    .clk_in(clk), .rst_in(rst2), .csync_in(csync_in2), .csync_out(csync_out2),
    .vsync_out(vsync_out2), .locked(locked2), .field_count(field_count2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise = 0;

  typedef struct {
    int         cyc;
    logic       locked;
    logic       vsync;
    logic [7:0] field;
  } ev_t;
  ev_t evq[$];
  ev_t ev;

  bit   m_locked, m_vert;
  int   m_broad, m_norm, m_field;
  logic e_locked = 1'b0, e_vsync = 1'b1;
  logic [7:0] e_field = 8'd0;
  logic d1 = 1'b1, d2 = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic void push_ev(input int t);
    ev_t e;
    e.cyc = t;
    e.locked = m_locked;
    e.vsync = !m_vert;
    e.field = m_field[7:0];
    evq.push_back(e);
  endfunction

  function automatic void model_clear();
    m_locked = 0; m_vert = 0; m_broad = 0; m_norm = 0; m_field = 0;
  endfunction

  // pulse-level rules: effect visible 4 clocks after the csync_in rising edge
  function automatic void classify(input int lo, input int c);
    if (lo < GLI) return;
    if (lo >= BRD) begin
      m_broad++; m_norm = 0;
      if (m_locked && !m_vert && m_broad >= BMIN) begin
        m_vert = 1;
        m_field = (m_field + 1) % 256;
      end
    end else begin
      m_norm++; m_broad = 0;
      if (!m_locked && m_norm >= LOCKN) m_locked = 1;
      else if (m_vert) m_vert = 0;
    end
    push_ev(c + 4);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin d2 = 1'b1; d1 = 1'b1; end
    else begin d2 = d1; d1 = csync_in; end
  end

  initial forever begin
    @(negedge clk);
    if (cyc >= 1) begin
      while (evq.size() > 0 && evq[0].cyc <= cyc) begin
        ev = evq.pop_front();
        e_locked = ev.locked; e_vsync = ev.vsync; e_field = ev.field;
      end
      chk("csync_out", csync_out, d2);
      chk("locked", locked, e_locked);
      chk("vsync_out", vsync_out, e_vsync);
      chk("field_count", field_count, e_field);
    end
  end

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) wait_neg();
  endtask

  task automatic do_low(input int lo);
    csync_in = 1'b0;
    repeat (lo) wait_neg();
    csync_in = 1'b1;
    last_rise = cyc;
    classify(lo, cyc);
  endtask

  task automatic do_high(input int hi);
    if (hi >= TMO) begin
      m_locked = 0; m_vert = 0; m_broad = 0; m_norm = 0;
      push_ev(last_rise + 3 + TMO);
    end
    wait_until(last_rise + hi);
  endtask

  task automatic line();
    do_low(47);
    do_high(593);
  endtask

  task automatic p2(input int lo, input int hi);
    csync_in2 = 1'b0;
    repeat (lo) wait_neg();
    csync_in2 = 1'b1;
    repeat (hi) wait_neg();
  endtask

  task automatic vsync_edges(input int fld);
    for (int i = 0; i < 5; i++) begin
      do_low(270);
      if (i == 2) begin
        wait_until(last_rise + 3);
        chk("vfall_m1", vsync_out, 1'b1);
        wait_until(last_rise + 4);
        chk("vfall", vsync_out, 1'b0);
        chk("field_lit", field_count, fld);
      end
      if (i < 4 && fld == 2) begin
        do_high(20); do_low(5); do_high(25);
      end else begin
        do_high(50);
      end
    end
    do_low(47);
    wait_until(last_rise + 3);
    chk("vrise_m1", vsync_out, 1'b0);
    wait_until(last_rise + 4);
    chk("vrise", vsync_out, 1'b1);
    do_high(593);
    line();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog cyc=%0d got=running want=done", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; csync_in = 1'b1; rst2 = 1'b1; csync_in2 = 1'b1;
    model_clear();
    push_ev(1);
    repeat (3) wait_neg();
    chk("rst_locked", locked, 1'b0);
    chk("rst_vsync", vsync_out, 1'b1);
    chk("rst_field", field_count, 8'd0);
    chk("rst_csync", csync_out, 1'b1);
    rst = 1'b0; rst2 = 1'b0;

    fork
      begin
        repeat (10) wait_neg();
        repeat (3) line();
        do_low(47);
        wait_until(last_rise + 3);
        chk("lock_m1", locked, 1'b0);
        wait_until(last_rise + 4);
        chk("lock", locked, 1'b1);
        chk("lock_vsync", vsync_out, 1'b1);
        do_high(593);

        vsync_edges(1);
        vsync_edges(2);

        do_low(47);
        do_high(TMO);
        wait_until(last_rise + TMO + 2);
        chk("tmo_m1", locked, 1'b1);
        wait_until(last_rise + TMO + 3);
        chk("tmo_locked", locked, 1'b0);
        chk("tmo_vsync", vsync_out, 1'b1);
        repeat (2) begin do_low(270); do_high(50); end
        line();
        chk("no_relock", locked, 1'b0);
        repeat (4) line();
        chk("relock", locked, 1'b1);

        repeat (3) begin do_low(270); do_high(50); end
        chk("vert_before_rst", vsync_out, 1'b0);
        chk("field3", field_count, 8'd3);
        rst = 1'b1;
        evq.delete();
        model_clear();
        push_ev(cyc + 1);
        wait_neg();
        chk("rst_vert_vsync", vsync_out, 1'b1);
        chk("rst_vert_locked", locked, 1'b0);
        chk("rst_vert_field", field_count, 8'd0);
        rst = 1'b0;
        wait_neg();
        repeat (4) line();
        chk("relock_after_rst", locked, 1'b1);
      end
      begin
        repeat (5) wait_neg();
        repeat (4) p2(3, 5);
        chk("w_lock", locked2, 1'b1);
        for (int i = 1; i <= 256; i++) begin
          repeat (3) p2(12, 3);
          p2(3, 5);
          chk("w_field", field_count2, i % 256);
          chk("w_vsync", vsync_out2, 1'b1);
          chk("w_locked", locked2, 1'b1);
        end
        chk("w_wrap", field_count2, 8'd0);
      end
    join

    repeat (2) wait_neg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
